// File: rtl/leaderboard.sv
// Leaderboard for a stopwatch.
// Keeps the three fastest and the three slowest recorded times, and
// pulses a rank-specific sound when a new time enters either board.
// It also reports which boards the last submission changed and drives
// a one-hot rank LED from the display mode.
module leaderboard (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [38:0] time_in,
  input  logic [1:0]  stopwatch_mode,
  input  logic [2:0]  display_mode,
  output logic [38:0] fast_1,
  output logic [38:0] fast_2,
  output logic [38:0] fast_3,
  output logic [38:0] slow_1,
  output logic [38:0] slow_2,
  output logic [38:0] slow_3,
  output logic        signal_sound_1,
  output logic        signal_sound_2,
  output logic        signal_sound_3,
  output logic [2:0]  leaderboard_LED,
  output logic [1:0]  slow_or_fast
);

  localparam logic [1:0] MODE_RECORD = 2'b01;

  // One board: rank 1 is held in index 0.
  typedef logic [2:0][38:0] board_t;

  // Return a one-hot mask of the lowest set bit, i.e. the best rank that
  // accepts the new time. All zeros means the time is not placed.
  function automatic logic [2:0] first_hit(input logic [2:0] hit);
    logic [2:0] onehot;
    onehot = 3'b000;
    if (hit[0]) begin
      onehot = 3'b001;
    end else if (hit[1]) begin
      onehot = 3'b010;
    end else if (hit[2]) begin
      onehot = 3'b100;
    end else begin
      onehot = 3'b000;
    end
    return onehot;
  endfunction

  // Place t at the rank selected by ins.
  // Entries below that rank move down one place, and the old rank-3
  // entry falls off the board. When ins is zero the board is returned
  // unchanged.
  function automatic board_t insert_entries(input board_t entries,
                                            input logic [2:0] ins,
                                            input logic [38:0] t);
    board_t nxt;
    nxt = entries;
    if (ins[0]) begin
      nxt[0] = t;
      nxt[1] = entries[0];
      nxt[2] = entries[1];
    end else if (ins[1]) begin
      nxt[1] = t;
      nxt[2] = entries[1];
    end else if (ins[2]) begin
      nxt[2] = t;
    end else begin
      nxt = entries;
    end
    return nxt;
  endfunction

  // Apply the same shift to the valid bits. The inserted slot becomes
  // valid, and the dropped rank-3 valid bit is lost with its entry.
  function automatic logic [2:0] insert_valid(input logic [2:0] vld,
                                              input logic [2:0] ins);
    logic [2:0] nxt;
    nxt = vld;
    if (ins[0]) begin
      nxt = {vld[1], vld[0], 1'b1};
    end else if (ins[1]) begin
      nxt = {vld[1], 1'b1, vld[0]};
    end else if (ins[2]) begin
      nxt = {1'b1, vld[1], vld[0]};
    end else begin
      nxt = vld;
    end
    return nxt;
  endfunction

  logic [38:0] last_time_r;
  board_t      fast_r;
  board_t      slow_r;
  logic [2:0]  fast_vld_r;
  logic [2:0]  slow_vld_r;
  logic [2:0]  sound_r;
  logic [1:0]  slow_or_fast_r;

  logic        submit_s;
  logic [2:0]  fast_hit_s;
  logic [2:0]  slow_hit_s;
  logic [2:0]  fast_ins_s;
  logic [2:0]  slow_ins_s;
  logic        fast_chg_s;
  logic        slow_chg_s;
  board_t      fast_next_s;
  board_t      slow_next_s;
  logic [2:0]  fast_vld_next_s;
  logic [2:0]  slow_vld_next_s;

  // Detect a submission and work out where the new time lands on each board.
  // The comparisons are strict, so a time equal to an existing entry ranks
  // after that entry and never displaces it.
  always_comb begin
    submit_s = (stopwatch_mode == MODE_RECORD) &&
               (time_in != 39'd0) &&
               (time_in != last_time_r);
    fast_hit_s = 3'b000;
    slow_hit_s = 3'b000;
    for (int k = 0; k < 3; k++) begin
      fast_hit_s[k] = !fast_vld_r[k] || (time_in < fast_r[k]);
      slow_hit_s[k] = !slow_vld_r[k] || (time_in > slow_r[k]);
    end
    fast_ins_s      = first_hit(fast_hit_s);
    slow_ins_s      = first_hit(slow_hit_s);
    fast_chg_s      = |fast_ins_s;
    slow_chg_s      = |slow_ins_s;
    fast_next_s     = insert_entries(fast_r, fast_ins_s, time_in);
    slow_next_s     = insert_entries(slow_r, slow_ins_s, time_in);
    fast_vld_next_s = insert_valid(fast_vld_r, fast_ins_s);
    slow_vld_next_s = insert_valid(slow_vld_r, slow_ins_s);
  end

  // Update the boards, last_time, the rank pulses and the change flags
  // on a submission. The rank pulses clear on every other cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_time_r    <= 39'd0;
      fast_r         <= '0;
      slow_r         <= '0;
      fast_vld_r     <= 3'b000;
      slow_vld_r     <= 3'b000;
      sound_r        <= 3'b000;
      slow_or_fast_r <= 2'b00;
    end else if (submit_s) begin
      last_time_r    <= time_in;
      fast_r         <= fast_next_s;
      slow_r         <= slow_next_s;
      fast_vld_r     <= fast_vld_next_s;
      slow_vld_r     <= slow_vld_next_s;
      sound_r        <= fast_ins_s | slow_ins_s;
      slow_or_fast_r <= {slow_chg_s, fast_chg_s};
    end else begin
      sound_r        <= 3'b000;
    end
  end

  // Decode the rank LED from the leaderboard view selection.
  always_comb begin
    case (display_mode)
      3'b100:  leaderboard_LED = 3'b001;
      3'b101:  leaderboard_LED = 3'b010;
      3'b110:  leaderboard_LED = 3'b100;
      default: leaderboard_LED = 3'b000;
    endcase
  end

  // Empty slots hold zero, so the outputs come straight from the board registers.
  assign fast_1         = fast_r[0];
  assign fast_2         = fast_r[1];
  assign fast_3         = fast_r[2];
  assign slow_1         = slow_r[0];
  assign slow_2         = slow_r[1];
  assign slow_3         = slow_r[2];
  assign signal_sound_1 = sound_r[0];
  assign signal_sound_2 = sound_r[1];
  assign signal_sound_3 = sound_r[2];
  assign slow_or_fast   = slow_or_fast_r;

endmodule

// File: tb/tb_leaderboard.sv
// Directed testbench for the leaderboard.
// Every expected value below was worked out by hand.
module tb_leaderboard;

  logic        clk;
  logic        rst_n;
  logic [38:0] time_in;
  logic [1:0]  stopwatch_mode;
  logic [2:0]  display_mode;
  logic [38:0] fast_1, fast_2, fast_3;
  logic [38:0] slow_1, slow_2, slow_3;
  logic        signal_sound_1, signal_sound_2, signal_sound_3;
  logic [2:0]  leaderboard_LED;
  logic [1:0]  slow_or_fast;

  int checks;
  int failures;

  leaderboard dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .time_in        (time_in),
    .stopwatch_mode (stopwatch_mode),
    .display_mode   (display_mode),
    .fast_1         (fast_1),
    .fast_2         (fast_2),
    .fast_3         (fast_3),
    .slow_1         (slow_1),
    .slow_2         (slow_2),
    .slow_3         (slow_3),
    .signal_sound_1 (signal_sound_1),
    .signal_sound_2 (signal_sound_2),
    .signal_sound_3 (signal_sound_3),
    .leaderboard_LED(leaderboard_LED),
    .slow_or_fast   (slow_or_fast)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so that a stuck run still ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [38:0] obs, input logic [38:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_boards(input string tag,
                            input logic [38:0] f1, input logic [38:0] f2, input logic [38:0] f3,
                            input logic [38:0] s1, input logic [38:0] s2, input logic [38:0] s3);
    chk({tag, ".fast_1"}, fast_1, f1);
    chk({tag, ".fast_2"}, fast_2, f2);
    chk({tag, ".fast_3"}, fast_3, f3);
    chk({tag, ".slow_1"}, slow_1, s1);
    chk({tag, ".slow_2"}, slow_2, s2);
    chk({tag, ".slow_3"}, slow_3, s3);
  endtask

  task automatic chk_flags(input string tag, input logic [2:0] snd, input logic [1:0] sof);
    chk({tag, ".sound"}, {36'd0, signal_sound_3, signal_sound_2, signal_sound_1}, {36'd0, snd});
    chk({tag, ".slow_or_fast"}, {37'd0, slow_or_fast}, {37'd0, sof});
  endtask

  // Drive inputs at the falling edge, then sample 1 ns after the next rising edge.
  task automatic step(input logic [1:0] mode, input logic [38:0] t);
    @(negedge clk);
    stopwatch_mode = mode;
    time_in        = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    time_in        = 39'd0;
    stopwatch_mode = 2'b00;
    display_mode   = 3'b100;

    // Reset state.
    #2;
    chk_boards("reset", 39'd0, 39'd0, 39'd0, 39'd0, 39'd0, 39'd0);
    chk_flags("reset", 3'b000, 2'b00);
    chk("reset.led", {36'd0, leaderboard_LED}, {36'd0, 3'b001});
    @(negedge clk);
    rst_n = 1'b1;

    // First submission on an empty board.
    step(2'b01, 39'd143000);
    chk_boards("s143", 39'd143000, 39'd0, 39'd0, 39'd143000, 39'd0, 39'd0);
    chk_flags("s143", 3'b001, 2'b11);
    step(2'b00, 39'd143000);
    chk_flags("s143_idle", 3'b000, 2'b11);

    // Second submission: rank 1 on the fast board, rank 2 on the slow board.
    step(2'b01, 39'd142000);
    chk_boards("s142", 39'd142000, 39'd143000, 39'd0, 39'd143000, 39'd142000, 39'd0);
    chk_flags("s142", 3'b011, 2'b11);
    step(2'b00, 39'd142000);
    chk_flags("s142_idle", 3'b000, 2'b11);

    // Third submission: rank 1 on the fast board, rank 3 on the slow board.
    step(2'b01, 39'd139000);
    chk_boards("s139", 39'd139000, 39'd142000, 39'd143000, 39'd143000, 39'd142000, 39'd139000);
    chk_flags("s139", 3'b101, 2'b11);

    // Fourth submission: the fast board is full so only the slow board changes.
    step(2'b01, 39'd150000);
    chk_boards("s150", 39'd139000, 39'd142000, 39'd143000, 39'd150000, 39'd143000, 39'd142000);
    chk_flags("s150", 3'b001, 2'b10);

    // Holding the same time with recording enabled is not a new submission.
    step(2'b01, 39'd150000);
    chk_boards("hold", 39'd139000, 39'd142000, 39'd143000, 39'd150000, 39'd143000, 39'd142000);
    chk_flags("hold", 3'b000, 2'b10);

    // A zero time is ignored.
    step(2'b01, 39'd0);
    chk_boards("zero", 39'd139000, 39'd142000, 39'd143000, 39'd150000, 39'd143000, 39'd142000);
    chk_flags("zero", 3'b000, 2'b10);

    // Mode codes other than 01 do not record.
    step(2'b10, 39'd100000);
    chk_boards("mode10", 39'd139000, 39'd142000, 39'd143000, 39'd150000, 39'd143000, 39'd142000);
    chk_flags("mode10", 3'b000, 2'b10);
    step(2'b11, 39'd200000);
    chk_boards("mode11", 39'd139000, 39'd142000, 39'd143000, 39'd150000, 39'd143000, 39'd142000);
    chk_flags("mode11", 3'b000, 2'b10);

    // Tie: 142000 ranks after the existing 142000 on the fast board (rank 3).
    // On the slow board it does not beat slow_3, so that board is unchanged.
    step(2'b01, 39'd142000);
    chk_boards("tie", 39'd139000, 39'd142000, 39'd142000, 39'd150000, 39'd143000, 39'd142000);
    chk_flags("tie", 3'b100, 2'b01);

    // Display mode sweep.
    display_mode = 3'b100; #1;
    chk("led100", {36'd0, leaderboard_LED}, {36'd0, 3'b001});
    display_mode = 3'b000; #1;
    chk("led000", {36'd0, leaderboard_LED}, {36'd0, 3'b000});
    display_mode = 3'b101; #1;
    chk("led101", {36'd0, leaderboard_LED}, {36'd0, 3'b010});
    display_mode = 3'b110; #1;
    chk("led110", {36'd0, leaderboard_LED}, {36'd0, 3'b100});
    display_mode = 3'b111; #1;
    chk("led111", {36'd0, leaderboard_LED}, {36'd0, 3'b000});

    // Reset in the middle of the sequence clears everything immediately.
    display_mode   = 3'b101;
    stopwatch_mode = 2'b00;
    rst_n          = 1'b0;
    #1;
    chk_boards("midrst", 39'd0, 39'd0, 39'd0, 39'd0, 39'd0, 39'd0);
    chk_flags("midrst", 3'b000, 2'b00);
    chk("midrst.led", {36'd0, leaderboard_LED}, {36'd0, 3'b010});
    @(negedge clk);
    rst_n = 1'b1;

    // After reset the next submission sees empty boards.
    step(2'b01, 39'd150000);
    chk_boards("post", 39'd150000, 39'd0, 39'd0, 39'd150000, 39'd0, 39'd0);
    chk_flags("post", 3'b001, 2'b11);
    step(2'b00, 39'd150000);
    chk_flags("post_idle", 3'b000, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
